kws_sram_arbiter: RTL and testbench

- Shares the single Wishbone port of the weight/feature SRAM (SRAM_1024x32) among several layer engines (linear, conv, softmax-normaliser, host loader).
- Each engine issues single-word read/write requests on a simple valid/ready port.
- The arbiter picks one requester round-robin, runs exactly one Wishbone classic cycle, and returns a one-cycle response to the winner.
- It sits between the KWS layer engines and the SRAM_1024x32 instance; it is the only Wishbone master on that SRAM.

---
 rtl/kws_sram_pkg.sv | 16 +
 rtl/kws_sram_arbiter_rr_picker.sv | 32 +++
 rtl/kws_sram_arbiter.sv | 148 ++++++++++++++
 tb/tb_kws_sram_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/kws_sram_pkg.sv
// Shared types and constants for the KWS SRAM arbiter and its round-robin picker.
// Fixed by the SRAM_1024x32 macro and the Wishbone handshake this arbiter implements.
package kws_sram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUS  = 2'b01,
      ST_RESP = 2'b10
   } arb_state_e;

   localparam int         SRAM_ADDR_W     = 10;
   localparam int         SRAM_DATA_W     = 32;
   localparam logic [3:0] SEL_ALL         = 4'b1111;
   localparam int         DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/kws_sram_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request after the last winner.
// Shared with the DMA/loader arbiter, so it carries no state of its own.
module rr_picker #(
   parameter int N     = 3,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Scan last+1 .. last+N modulo N and keep the first hit.
   always_comb begin
      int  cand_s;
      logic hit_s;
      grant  = {N{1'b0}};
      idx    = {IDX_W{1'b0}};
      any    = 1'b0;
      cand_s = 0;
      hit_s  = 1'b0;
      for (int i = 1; i <= N; i++) begin
         cand_s = ((int'(last) + i) >= N) ? (int'(last) + i - N) : (int'(last) + i);
         hit_s  = !any && req[cand_s];
         grant[cand_s] = grant[cand_s] | hit_s;
         idx    = hit_s ? IDX_W'(cand_s) : idx;
         any    = any | hit_s;
      end
   end

endmodule

// File: rtl/kws_sram_arbiter.sv
// Round-robin arbiter giving the KWS layer engines single-word access to the
// SRAM_1024x32 through one Wishbone classic master port, with an ack timeout.
module kws_sram_arbiter
   import kws_sram_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = SRAM_ADDR_W,
   parameter int DATA_W  = SRAM_DATA_W,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   input  logic [NUM_REQ*4-1:0]      req_sel,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic                      wbs_cyc_o,
   output logic                      wbs_stb_o,
   output logic                      wbs_we_o,
   output logic [3:0]                wbs_sel_o,
   output logic [31:0]               wbs_adr_o,
   output logic [31:0]               wbs_dat_o,
   input  logic                      wbs_ack_i,
   input  logic [31:0]               wbs_dat_i
);

   localparam int               IDX_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
   localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   arb_state_e          state_r;
   arb_state_e          state_nxt_s;
   logic [IDX_W-1:0]    last_r;
   logic [IDX_W-1:0]    win_idx_s;
   logic [NUM_REQ-1:0]  win_gnt_s;
   logic                win_any_s;
   logic [7:0]          cnt_r;
   logic                timeout_s;
   logic                accept_s;
   logic                bus_done_s;

   rr_picker #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_rr_picker (
      .req   (req_valid),
      .last  (last_r),
      .grant (win_gnt_s),
      .idx   (win_idx_s),
      .any   (win_any_s)
   );

   assign timeout_s = (cnt_r == TMO_LAST);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: state_nxt_s = accept_s   ? ST_BUS  : ST_IDLE;
         ST_BUS:  state_nxt_s = bus_done_s ? ST_RESP : ST_BUS;
         ST_RESP: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Per-state strobes; ack in the timeout cycle still counts as a normal completion.
   always_comb begin
      req_ready  = {NUM_REQ{1'b0}};
      accept_s   = 1'b0;
      bus_done_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            req_ready = win_gnt_s;
            accept_s  = win_any_s;
         end
         ST_BUS:  bus_done_s = wbs_ack_i | timeout_s;
         ST_RESP: req_ready  = {NUM_REQ{1'b0}};
         default: req_ready  = {NUM_REQ{1'b0}};
      endcase
   end

   // Wishbone master outputs, round-robin pointer and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbs_cyc_o <= 1'b0;
         wbs_stb_o <= 1'b0;
         wbs_we_o  <= 1'b0;
         wbs_sel_o <= 4'b0000;
         wbs_adr_o <= 32'h0000_0000;
         wbs_dat_o <= 32'h0000_0000;
         last_r    <= IDX_W'(NUM_REQ - 1);
         rsp_valid <= {NUM_REQ{1'b0}};
         rsp_rdata <= {DATA_W{1'b0}};
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= bus_done_s ? (ONE_HOT0 << last_r) : {NUM_REQ{1'b0}};
         if (accept_s) begin
            wbs_cyc_o <= 1'b1;
            wbs_stb_o <= 1'b1;
            wbs_we_o  <= req_we[win_idx_s];
            wbs_sel_o <= req_sel[int'(win_idx_s)*4 +: 4];
            wbs_adr_o <= 32'(req_addr[int'(win_idx_s)*ADDR_W +: ADDR_W]);
            wbs_dat_o <= 32'(req_wdata[int'(win_idx_s)*DATA_W +: DATA_W]);
            last_r    <= win_idx_s;
         end else if (bus_done_s) begin
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            wbs_we_o  <= 1'b0;
            wbs_sel_o <= 4'b0000;
            wbs_adr_o <= 32'h0000_0000;
            wbs_dat_o <= 32'h0000_0000;
            rsp_rdata <= (wbs_ack_i && !wbs_we_o) ? DATA_W'(wbs_dat_i) : {DATA_W{1'b0}};
            rsp_err   <= !wbs_ack_i;
         end else begin
            wbs_cyc_o <= wbs_cyc_o;
            wbs_stb_o <= wbs_stb_o;
         end
      end
   end

   // Ack-timeout counter: runs while waiting in BUS, cleared in RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= 8'd0;
      end else if ((state_r == ST_BUS) && !bus_done_s) begin
         cnt_r <= cnt_r + 8'd1;
      end else if (state_r == ST_RESP) begin
         cnt_r <= 8'd0;
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: tb/tb_kws_sram_arbiter.sv
// Directed bench for kws_sram_arbiter: vector table of single transactions,
// then mid-BUS reset followed by round-robin fairness with all requesters held.
module tb_kws_sram_arbiter;
   import kws_sram_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  req_valid = 3'b000;
   logic [2:0]  req_we = 3'b000;
   logic [29:0] req_addr = 30'd0;
   logic [95:0] req_wdata = 96'd0;
   logic [11:0] req_sel = 12'd0;
   logic [2:0]  req_ready;
   logic [2:0]  rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        wbs_cyc_o, wbs_stb_o, wbs_we_o;
   logic [3:0]  wbs_sel_o;
   logic [31:0] wbs_adr_o, wbs_dat_o;
   logic        wbs_ack_i = 1'b0;
   logic [31:0] wbs_dat_i = 32'hBAD0_BAD0;

   int checks = 0;
   int failures = 0;
   int ack_lat = 1;
   int bus_cyc = 0;
   int cyc_cnt = 0;
   logic [31:0] mem [0:1023];
   logic [2:0]  rsp_log [$];

   kws_sram_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_sel(req_sel), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
      .wbs_sel_o(wbs_sel_o), .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o),
      .wbs_ack_i(wbs_ack_i), .wbs_dat_i(wbs_dat_i)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt++;

   // SRAM model: acks on the ack_lat-th cycle of stb (ack_lat 0 = never acks).
   always begin
      @(posedge clk);
      #1;
      if (!rst_n || !wbs_stb_o || wbs_ack_i) begin
         bus_cyc   = 0;
         wbs_ack_i = 1'b0;
         wbs_dat_i = 32'hBAD0_BAD0;
      end else begin
         bus_cyc++;
         if (ack_lat != 0 && bus_cyc == ack_lat) begin
            wbs_ack_i = 1'b1;
            if (wbs_we_o) begin
               for (int b = 0; b < 4; b++)
                  if (wbs_sel_o[b]) mem[wbs_adr_o[9:0]][b*8 +: 8] = wbs_dat_o[b*8 +: 8];
               wbs_dat_i = 32'hFFFF_FFFF;
            end else begin
               wbs_dat_i = mem[wbs_adr_o[9:0]];
            end
         end else begin
            wbs_ack_i = 1'b0;
         end
      end
   end

   always @(negedge clk) if (rst_n && rsp_valid != 3'b000) rsp_log.push_back(rsp_valid);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive_req(input int r, input logic we, input logic [9:0] addr,
                            input logic [31:0] wdata, input logic [3:0] sel);
      req_valid = 3'b000;
      req_valid[r] = 1'b1;
      req_we[r] = we;
      req_addr[r*10 +: 10] = addr;
      req_wdata[r*32 +: 32] = wdata;
      req_sel[r*4 +: 4] = sel;
   endtask

   typedef struct {
      int          req;
      logic        we;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      int          lat;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_wait;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic [2:0]  oh;
      logic [31:0] exp_adr;
      int          waited;
      int          last_grant_cyc;

      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[10'h014] = 32'h00A5_5A00;

      vecs[0] = '{0, 1'b0, 10'h014, 32'h0,          4'b1111, 1,  32'h00A5_5A00, 1'b0, 1};
      vecs[1] = '{2, 1'b1, 10'h3FF, 32'hDEAD_BEEF, SEL_ALL, 1,  32'h0,         1'b0, 1};
      vecs[2] = '{2, 1'b0, 10'h3FF, 32'h0,          4'b1111, 2,  32'hDEAD_BEEF, 1'b0, 2};
      vecs[3] = '{1, 1'b1, 10'h005, 32'h1234_5678, 4'b0011, 3,  32'h0,         1'b0, 3};
      vecs[4] = '{1, 1'b0, 10'h005, 32'h0,          4'b0101, 1,  32'h0000_5678, 1'b0, 1};
      vecs[5] = '{0, 1'b0, 10'h3FF, 32'h0,          4'b1111, 0,  32'h0,         1'b1, 15};
      vecs[6] = '{0, 1'b0, 10'h014, 32'h0,          4'b1111, 1,  32'h00A5_5A00, 1'b0, 1};
      vecs[7] = '{1, 1'b0, 10'h3FF, 32'h0,          4'b1111, 15, 32'hDEAD_BEEF, 1'b0, 15};

      // Reset values
      #12;
      chk("rst_cyc", 32'(wbs_cyc_o), 32'h0);
      chk("rst_stb", 32'(wbs_stb_o), 32'h0);
      chk("rst_adr", wbs_adr_o, 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_err", 32'(rsp_err), 32'h0);
      chk("rst_ready", 32'(req_ready), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 8; v++) begin
         @(negedge clk);
         ack_lat = vecs[v].lat;
         drive_req(vecs[v].req, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].sel);
         oh = 3'b001 << vecs[v].req;
         exp_adr = {22'd0, vecs[v].addr};
         #1;
         chk($sformatf("v%0d_ready", v), 32'(req_ready), 32'(oh));
         @(posedge clk);
         #2;
         req_valid = 3'b000;
         chk($sformatf("v%0d_cycstb", v), 32'({wbs_cyc_o, wbs_stb_o}), 32'h3);
         chk($sformatf("v%0d_adr", v), wbs_adr_o, exp_adr);
         chk($sformatf("v%0d_we_sel", v), 32'({wbs_we_o, wbs_sel_o}), 32'({vecs[v].we, vecs[v].sel}));
         if (vecs[v].we) chk($sformatf("v%0d_dat", v), wbs_dat_o, vecs[v].wdata);
         else chk($sformatf("v%0d_ready_bus", v), 32'(req_ready), 32'h0);
         waited = 0;
         for (int w = 1; w <= 40; w++) begin
            @(posedge clk);
            #2;
            if (rsp_valid != 3'b000) begin
               waited = w;
               break;
            end
         end
         chk($sformatf("v%0d_latency", v), 32'(waited), 32'(vecs[v].exp_wait));
         chk($sformatf("v%0d_rsp_valid", v), 32'(rsp_valid), 32'(oh));
         chk($sformatf("v%0d_rdata", v), rsp_rdata, vecs[v].exp_rdata);
         chk($sformatf("v%0d_err", v), 32'(rsp_err), 32'(vecs[v].exp_err));
         chk($sformatf("v%0d_cyc_dropped", v), 32'(wbs_cyc_o | wbs_stb_o), 32'h0);
         @(posedge clk);
         #2;
         chk($sformatf("v%0d_rsp_one_cycle", v), 32'(rsp_valid), 32'h0);
         chk($sformatf("v%0d_rdata_hold", v), rsp_rdata, vecs[v].exp_rdata);
      end

      // Reset while stb is high: bus drops asynchronously, no response.
      rsp_log.delete();
      @(negedge clk);
      ack_lat = 0;
      drive_req(1, 1'b0, 10'h020, 32'h0, 4'b1111);
      repeat (3) @(posedge clk);
      #3;
      chk("mid_bus_stb_before", 32'(wbs_stb_o), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("mid_bus_rst_wbs", 32'({wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o}), 32'h0);
      chk("mid_bus_rst_adr", wbs_adr_o, 32'h0);
      req_valid = 3'b111;
      req_we = 3'b000;
      req_addr = {10'h014, 10'h014, 10'h014};
      ack_lat = 1;
      repeat (2) @(negedge clk);
      chk("rst_no_rsp", 32'(rsp_valid), 32'h0);
      rst_n = 1'b1;
      #1;

      // Fairness with all requesters held: 0,1,2,0,1,2, grants 3 cycles apart.
      last_grant_cyc = 0;
      for (int g = 0; g < 6; g++) begin
         waited = 0;
         for (int w = 0; w < 20 && req_ready == 3'b000; w++) begin
            @(negedge clk);
            #1;
            waited = w + 1;
         end
         chk($sformatf("fair_grant%0d", g), 32'(req_ready), 32'(3'b001 << (g % 3)));
         if (g > 0) chk($sformatf("fair_spacing%0d", g), 32'(cyc_cnt - last_grant_cyc), 32'd3);
         last_grant_cyc = cyc_cnt;
         @(negedge clk);
         #1;
      end
      req_valid = 3'b000;
      repeat (6) @(negedge clk);
      chk("fair_rsp_count", 32'(rsp_log.size()), 32'd6);
      for (int g = 0; g < 6 && g < rsp_log.size(); g++)
         chk($sformatf("fair_rsp%0d", g), 32'(rsp_log[g]), 32'(3'b001 << (g % 3)));
      chk("fair_rdata", rsp_rdata, 32'h00A5_5A00);
      chk("fair_err", 32'(rsp_err), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
